clock_pulse_scheduler: RTL and testbench

Run/stop and configuration controller for the clock pulse conversion path. It derives a divided pulse clk_N from clk_in with a programmable period and high time. It accepts new settings through a valid/ready handshake and applies them only at period boundaries, so clk_N never produces a runt pulse. It sits between the system controller and the clock-conversion datapath, and also emits a per-period tick strobe and a period count.

---
 rtl/clock_pulse_scheduler.sv | 156 +++++++++++++++
 tb/tb_clock_pulse_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/clock_pulse_scheduler.sv
// Run/stop and configuration controller producing a divided pulse clk_N from clk_in.
// New period/high-time settings are taken only at period boundaries so clk_N never produces a runt pulse.
module clock_pulse_scheduler #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 4,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_N,
    output logic             tick,
    output logic             busy,
    output logic [7:0]       period_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0] div_r, div_nxt_s;
    logic [CNT_W-1:0] high_r, high_nxt_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_nxt_s;
    logic [CNT_W-1:0] pend_high_r, pend_high_nxt_s;
    logic             pend_r, pend_nxt_s;
    logic             clk_n_r, tick_r, busy_r, cfg_ready_r, cfg_err_r;
    logic [7:0]       period_cnt_r;
    logic             active_s, wrap_s, accept_s, legal_s, err_nxt_s;
    logic             busy_nxt_s, tick_nxt_s, clk_n_nxt_s, ready_nxt_s;

    function automatic logic cfg_is_legal(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] h);
        return (d >= CNT_W'(2)) && (h >= CNT_W'(1)) && (h < d);
    endfunction

    assign active_s = (state_r != IDLE);
    assign wrap_s   = active_s && (cnt_r == div_r - CNT_W'(1));
    assign accept_s = cfg_valid && cfg_ready_r;
    assign legal_s  = cfg_is_legal(cfg_div, cfg_high);

    // Next-state, counter and configuration bookkeeping for the coming edge.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        div_nxt_s       = div_r;
        high_nxt_s      = high_r;
        pend_nxt_s      = pend_r;
        pend_div_nxt_s  = pend_div_r;
        pend_high_nxt_s = pend_high_r;
        err_nxt_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start && !stop) state_nxt_s = RUN;
                else                state_nxt_s = IDLE;
            end
            RUN: begin
                if (stop) state_nxt_s = STOPPING;
                else      state_nxt_s = RUN;
            end
            STOPPING: begin
                // A fresh start request keeps the waveform running seamlessly.
                if (start && !stop) state_nxt_s = RUN;
                else if (wrap_s)    state_nxt_s = IDLE;
                else                state_nxt_s = STOPPING;
            end
            default: state_nxt_s = IDLE;
        endcase

        if (!active_s)   cnt_nxt_s = CNT_W'(0);
        else if (wrap_s) cnt_nxt_s = CNT_W'(0);
        else             cnt_nxt_s = cnt_r + CNT_W'(1);

        // Pending settings take effect on a period boundary, including the one that ends a stop.
        if (wrap_s && pend_r) begin
            div_nxt_s  = pend_div_r;
            high_nxt_s = pend_high_r;
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_r;
        end

        if (accept_s) begin
            if (!legal_s) begin
                err_nxt_s = 1'b1;
            end else if (!active_s) begin
                div_nxt_s  = cfg_div;
                high_nxt_s = cfg_high;
            end else begin
                pend_nxt_s      = 1'b1;
                pend_div_nxt_s  = cfg_div;
                pend_high_nxt_s = cfg_high;
            end
        end else begin
            err_nxt_s = 1'b0;
        end
    end

    // Outputs are derived from next-cycle state so they can be registered without a lag.
    always_comb begin
        busy_nxt_s  = (state_nxt_s != IDLE);
        tick_nxt_s  = busy_nxt_s && (cnt_nxt_s == CNT_W'(0));
        clk_n_nxt_s = busy_nxt_s && (cnt_nxt_s < high_nxt_s);
        ready_nxt_s = (state_nxt_s == IDLE) || !pend_nxt_s;
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_W'(0);
            div_r        <= CNT_W'(DEFAULT_DIV);
            high_r       <= CNT_W'(DEFAULT_HIGH);
            pend_r       <= 1'b0;
            pend_div_r   <= CNT_W'(0);
            pend_high_r  <= CNT_W'(0);
            clk_n_r      <= 1'b0;
            tick_r       <= 1'b0;
            busy_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
            cfg_err_r    <= 1'b0;
            period_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            div_r        <= div_nxt_s;
            high_r       <= high_nxt_s;
            pend_r       <= pend_nxt_s;
            pend_div_r   <= pend_div_nxt_s;
            pend_high_r  <= pend_high_nxt_s;
            clk_n_r      <= clk_n_nxt_s;
            tick_r       <= tick_nxt_s;
            busy_r       <= busy_nxt_s;
            cfg_ready_r  <= ready_nxt_s;
            cfg_err_r    <= err_nxt_s;
            period_cnt_r <= tick_nxt_s ? period_cnt_r + 8'd1 : period_cnt_r;
        end
    end

    assign clk_N      = clk_n_r;
    assign tick       = tick_r;
    assign busy       = busy_r;
    assign cfg_ready  = cfg_ready_r;
    assign cfg_err    = cfg_err_r;
    assign period_cnt = period_cnt_r;

endmodule

// File: tb/tb_clock_pulse_scheduler.sv
// Bench for clock_pulse_scheduler: a hand-derived vector table, directed corner sequences,
// and random stimulus compared against a period-level reference model.
module tb_clock_pulse_scheduler;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
    logic [15:0] cfg_div = 16'd0, cfg_high = 16'd0;
    logic        cfg_ready, cfg_err, clk_N, tick, busy;
    logic [7:0]  period_cnt;

    int errors = 0;
    int checks = 0;

    clock_pulse_scheduler #(.CNT_W(16), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
        .clk_in(clk_in), .rst(rst), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_N(clk_N), .tick(tick),
        .busy(busy), .period_cnt(period_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: whether a run is in progress, position inside the current period,
    // active settings and a queue of settings waiting for the next period boundary.
    bit m_active, m_stopping, m_err;
    int m_phase, m_div, m_high, m_periods;
    int q_div[$], q_high[$];

    function automatic bit m_ready();
        return !m_active || (q_div.size() == 0);
    endfunction

    task automatic model_update(input bit r, input bit s, input bit p, input bit v, input int d, input int h);
        bit acc, legal, was_active, eop;
        if (r) begin
            m_active = 0; m_stopping = 0; m_err = 0; m_phase = 0;
            m_div = 4; m_high = 2; m_periods = 0;
            q_div.delete(); q_high.delete();
        end else begin
            acc        = v && m_ready();
            legal      = (d >= 2) && (h >= 1) && (h < d);
            was_active = m_active;
            eop        = m_active && (m_phase == m_div - 1);
            if (!m_active) begin
                if (s && !p) begin
                    m_active = 1; m_stopping = 0; m_phase = 0; m_periods++;
                end
            end else begin
                if (eop && q_div.size() > 0) begin
                    m_div  = q_div.pop_front();
                    m_high = q_high.pop_front();
                end
                if (m_stopping && s && !p)   m_stopping = 0;
                else if (m_stopping && eop)  m_active = 0;
                else if (!m_stopping && p)   m_stopping = 1;
                if (!m_active) m_phase = 0;
                else begin
                    m_phase = eop ? 0 : m_phase + 1;
                    if (m_phase == 0) m_periods++;
                end
            end
            m_err = acc && !legal;
            if (acc && legal) begin
                if (!was_active) begin m_div = d; m_high = h; end
                else begin q_div.push_back(d); q_high.push_back(h); end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model alongside the DUT, then sample after the edge.
    task automatic step(input bit r, input bit s, input bit p, input bit v, input int d, input int h);
        rst = r; start = s; stop = p; cfg_valid = v;
        cfg_div = 16'(d); cfg_high = 16'(h);
        @(posedge clk_in);
        model_update(r, s, p, v, d, h);
        #1;
    endtask

    task automatic check_model();
        check("clk_N",      int'(clk_N),      int'(m_active && (m_phase < m_high)));
        check("tick",       int'(tick),       int'(m_active && (m_phase == 0)));
        check("busy",       int'(busy),       int'(m_active));
        check("cfg_ready",  int'(cfg_ready),  int'(m_ready()));
        check("cfg_err",    int'(cfg_err),    int'(m_err));
        check("period_cnt", int'(period_cnt), m_periods % 256);
    endtask

    typedef struct {
        bit r, s, p, v;
        int d, h;
        bit e_clk, e_tick, e_busy, e_ready, e_err;
        int e_pcnt;
    } vec_t;

    vec_t tbl[13];
    bit   saw_wrap;
    int   prev_pcnt;

    initial begin
        //          r  s  p  v  d  h   clk tick busy rdy err pcnt
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0,  0,   0,   1,  0,  0};
        tbl[1]  = '{0, 0, 0, 1, 5, 2,  0,  0,   0,   1,  0,  0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0,  1,  1,   1,   1,  0,  1};
        tbl[3]  = '{0, 1, 0, 0, 0, 0,  1,  0,   1,   1,  0,  1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,  0,  0,   1,   1,  0,  1};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,  0,  0,   1,   1,  0,  1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,  0,  0,   1,   1,  0,  1};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  1,  1,   1,   1,  0,  2};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,  1,  0,   1,   1,  0,  2};
        tbl[9]  = '{0, 0, 0, 1, 5, 5,  0,  0,   1,   1,  1,  2};
        tbl[10] = '{0, 0, 0, 0, 0, 0,  0,  0,   1,   1,  0,  2};
        tbl[11] = '{0, 0, 0, 1, 1, 0,  0,  0,   1,   1,  1,  2};
        tbl[12] = '{0, 0, 0, 0, 0, 0,  1,  1,   1,   1,  0,  3};

        @(negedge clk_in);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].d, tbl[i].h);
            check($sformatf("tbl%0d_clk_N", i),      int'(clk_N),      int'(tbl[i].e_clk));
            check($sformatf("tbl%0d_tick", i),       int'(tick),       int'(tbl[i].e_tick));
            check($sformatf("tbl%0d_busy", i),       int'(busy),       int'(tbl[i].e_busy));
            check($sformatf("tbl%0d_cfg_ready", i),  int'(cfg_ready),  int'(tbl[i].e_ready));
            check($sformatf("tbl%0d_cfg_err", i),    int'(cfg_err),    int'(tbl[i].e_err));
            check($sformatf("tbl%0d_period_cnt", i), int'(period_cnt), tbl[i].e_pcnt);
        end

        // Reconfigure while running: offer 4/1 at cnt=2 of a div=5 period.
        step(1, 0, 0, 0, 0, 0); check_model();
        step(0, 0, 0, 1, 5, 2); check_model();
        step(0, 1, 0, 0, 0, 0); check_model();
        step(0, 1, 0, 0, 0, 0); check_model();
        step(0, 1, 0, 0, 0, 0); check_model();
        step(0, 1, 0, 1, 4, 1); check_model();
        check("reconfig_ready_low", int'(cfg_ready), 0);
        for (int i = 0; i < 12; i++) begin step(0, 1, 0, 0, 0, 0); check_model(); end

        // Stop mid-period, go idle, then restart and cancel a stop while STOPPING.
        step(0, 0, 1, 0, 0, 0); check_model();
        for (int i = 0; i < 6; i++) begin step(0, 0, 0, 0, 0, 0); check_model(); end
        check("stopped_busy", int'(busy), 0);
        step(0, 1, 0, 0, 0, 0); check_model();
        step(0, 0, 1, 0, 0, 0); check_model();
        step(0, 1, 0, 0, 0, 0); check_model();
        for (int i = 0; i < 8; i++) begin step(0, 0, 0, 0, 0, 0); check_model(); end
        check("restart_busy", int'(busy), 1);

        // Reset mid-run with a config pending: defaults 4/2 must come back.
        step(0, 0, 0, 1, 6, 3); check_model();
        step(1, 1, 0, 0, 0, 0); check_model();
        check("rst_period_cnt", int'(period_cnt), 0);
        for (int i = 0; i < 10; i++) begin step(0, 1, 0, 0, 0, 0); check_model(); end

        // period_cnt wrap with the shortest legal period.
        step(1, 0, 0, 0, 0, 0); check_model();
        step(0, 0, 0, 1, 2, 1); check_model();
        saw_wrap  = 0;
        prev_pcnt = int'(period_cnt);
        for (int i = 0; i < 520; i++) begin
            step(0, 1, 0, 0, 0, 0); check_model();
            if (prev_pcnt == 255 && period_cnt == 8'd0) saw_wrap = 1;
            prev_pcnt = int'(period_cnt);
        end
        check("period_cnt_wrapped", int'(saw_wrap), 1);

        // Random stimulus against the model.
        step(1, 0, 0, 0, 0, 0); check_model();
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
